// File: rtl/comm_pkg.sv
// Opcode constants, command encoding and operand counts
// shared by the command parser and its testbench.
package comm_pkg;

   localparam logic [7:0] OP_CONNECT    = 8'hA5;
   localparam logic [7:0] OP_DISCONNECT = 8'h5A;
   localparam logic [7:0] OP_WRITE      = 8'h10;
   localparam logic [7:0] OP_READ       = 8'h20;
   localparam logic [7:0] OP_FILL       = 8'h30;

   localparam logic [2:0] N_WRITE = 3'd3;
   localparam logic [2:0] N_READ  = 3'd1;
   localparam logic [2:0] N_FILL  = 3'd4;

   typedef enum logic [1:0] {
      CMD_NONE  = 2'b00,
      CMD_WRITE = 2'b01,
      CMD_READ  = 2'b10,
      CMD_FILL  = 2'b11
   } cmd_t;

   function automatic cmd_t decode_op(input logic [7:0] op);
      cmd_t c;
      case (op)
         OP_WRITE: c = CMD_WRITE;
         OP_READ:  c = CMD_READ;
         OP_FILL:  c = CMD_FILL;
         default:  c = CMD_NONE;
      endcase
      return c;
   endfunction

   function automatic logic [2:0] opd_need(input cmd_t c);
      logic [2:0] n;
      case (c)
         CMD_WRITE: n = N_WRITE;
         CMD_READ:  n = N_READ;
         CMD_FILL:  n = N_FILL;
         default:   n = 3'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/cmd_parser_if.sv
// Byte stream in, decoded command and operand buffer out.
interface cmd_parser_if;
   import comm_pkg::*;

   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        opds_counter_rst;
   logic        send_ack;
   logic        start_bit;
   logic        valid_cmd;
   logic        last_opds;
   logic        connect;
   logic        disconnect;
   cmd_t        cmd_code;
   logic [31:0] opds;
   logic [2:0]  opd_cnt;
   logic        err_cmd;
   logic        overrun;

   modport master (
      output rx_data, rx_valid, opds_counter_rst, send_ack,
      input  start_bit, valid_cmd, last_opds, connect, disconnect,
      input  cmd_code, opds, opd_cnt, err_cmd, overrun
   );

   modport slave (
      input  rx_data, rx_valid, opds_counter_rst, send_ack,
      output start_bit, valid_cmd, last_opds, connect, disconnect,
      output cmd_code, opds, opd_cnt, err_cmd, overrun
   );

endinterface

// File: rtl/cmd_parser.sv
// UART command parser: opcode decode, operand collection,
// link connect/disconnect tracking, all outputs registered.
module cmd_parser
   import comm_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   cmd_parser_if.slave  bus
);

   typedef enum logic [1:0] {
      S_CMD  = 2'd0,
      S_OPDS = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        link_q, link_d;
   logic        ovr_q, ovr_d;
   logic [31:0] opds_q, opds_d;
   logic [2:0]  cnt_q, cnt_d;
   cmd_t        code_q, code_d;
   logic        vc_q, vc_d;
   logic        start_q, start_d;
   logic        last_q, last_d;
   logic        conn_q, conn_d;
   logic        disc_q, disc_d;
   logic        err_q, err_d;

   logic [2:0]  cnt_inc;
   cmd_t        op_cmd;
   logic        is_conn;
   logic        is_disc;

   assign cnt_inc = cnt_q + 3'd1;
   assign op_cmd  = decode_op(bus.rx_data);
   assign is_conn = bus.rx_data == OP_CONNECT;
   assign is_disc = bus.rx_data == OP_DISCONNECT;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_CMD;
         link_q  <= 1'b0;
         ovr_q   <= 1'b0;
         opds_q  <= '0;
         cnt_q   <= '0;
         code_q  <= CMD_NONE;
         vc_q    <= 1'b0;
         start_q <= 1'b0;
         last_q  <= 1'b0;
         conn_q  <= 1'b0;
         disc_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         link_q  <= link_d;
         ovr_q   <= ovr_d;
         opds_q  <= opds_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         vc_q    <= vc_d;
         start_q <= start_d;
         last_q  <= last_d;
         conn_q  <= conn_d;
         disc_q  <= disc_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      link_d  = link_q;
      ovr_d   = ovr_q;
      opds_d  = opds_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      vc_d    = vc_q;
      start_d = 1'b0;
      last_d  = 1'b0;
      conn_d  = 1'b0;
      disc_d  = 1'b0;
      err_d   = 1'b0;

      // Abort outranks every byte and release in flight
      if (bus.opds_counter_rst) begin
         state_d = S_CMD;
         opds_d  = '0;
         cnt_d   = '0;
         code_d  = CMD_NONE;
         vc_d    = 1'b0;
      end else begin
         case (state_q)
            S_CMD: begin
               if (bus.rx_valid) begin
                  if (is_conn) begin
                     conn_d = 1'b1;
                     link_d = 1'b1;
                  end else if (is_disc) begin
                     disc_d = 1'b1;
                     link_d = 1'b0;
                  end else if (link_q) begin
                     start_d = 1'b1;
                     code_d  = op_cmd;
                     if (op_cmd != CMD_NONE) begin
                        vc_d    = 1'b1;
                        cnt_d   = '0;
                        opds_d  = '0;
                        state_d = S_OPDS;
                     end else begin
                        vc_d  = 1'b0;
                        err_d = 1'b1;
                     end
                  end
               end
            end
            S_OPDS: begin
               if (bus.rx_valid) begin
                  if (is_conn) begin
                     conn_d = 1'b1;
                     link_d = 1'b1;
                  end else if (is_disc) begin
                     disc_d  = 1'b1;
                     link_d  = 1'b0;
                     state_d = S_CMD;
                     opds_d  = '0;
                     cnt_d   = '0;
                     code_d  = CMD_NONE;
                     vc_d    = 1'b0;
                  end else begin
                     opds_d[{cnt_q[1:0], 3'b000} +: 8] = bus.rx_data;
                     cnt_d = cnt_inc;
                     if (cnt_inc == opd_need(code_q)) begin
                        last_d  = 1'b1;
                        state_d = S_HOLD;
                     end
                  end
               end
            end
            S_HOLD: begin
               // A byte arriving here is lost, even alongside the release
               if (bus.rx_valid) ovr_d = 1'b1;
               if (bus.send_ack) begin
                  state_d = S_CMD;
                  code_d  = CMD_NONE;
                  vc_d    = 1'b0;
               end
            end
            default: state_d = S_CMD;
         endcase
      end
   end

   assign bus.start_bit  = start_q;
   assign bus.valid_cmd  = vc_q;
   assign bus.last_opds  = last_q;
   assign bus.connect    = conn_q;
   assign bus.disconnect = disc_q;
   assign bus.cmd_code   = code_q;
   assign bus.opds       = opds_q;
   assign bus.opd_cnt    = cnt_q;
   assign bus.err_cmd    = err_q;
   assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_cmd_parser.sv
// Self-checking bench for cmd_parser: directed scenarios plus
// random byte streams against a queue-based frame model.
module tb_cmd_parser;
   import comm_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   cmd_parser_if bus ();

   cmd_parser dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Frame model: link flag, current command, operand queue, frame-done flag
   bit       m_link;
   bit       m_ovr;
   int       m_cmd;
   bit       m_done;
   byte      m_q[$];
   bit       m_start, m_last, m_conn, m_disc, m_err;

   function automatic int need(input int c);
      case (c)
         1: return 3;
         2: return 1;
         3: return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] exp_opds();
      logic [31:0] r = '0;
      foreach (m_q[i]) r[8*i +: 8] = m_q[i];
      return r;
   endfunction

   task automatic model_reset();
      m_link = 0; m_ovr = 0; m_cmd = 0; m_done = 0;
      m_q.delete();
      m_start = 0; m_last = 0; m_conn = 0; m_disc = 0; m_err = 0;
   endtask

   task automatic model_step(input bit v, input logic [7:0] b,
                             input bit o, input bit a);
      m_start = 0; m_last = 0; m_conn = 0; m_disc = 0; m_err = 0;
      if (o) begin
         m_q.delete();
         m_cmd = 0;
         m_done = 0;
      end else if (m_done) begin
         if (v) m_ovr = 1;
         if (a) begin
            m_done = 0;
            m_cmd = 0;
         end
      end else if (v) begin
         if (b == 8'hA5) begin
            m_conn = 1;
            m_link = 1;
         end else if (b == 8'h5A) begin
            m_disc = 1;
            m_link = 0;
            if (m_cmd != 0) begin
               m_cmd = 0;
               m_q.delete();
            end
         end else if (m_cmd != 0) begin
            m_q.push_back(b);
            if (m_q.size() == need(m_cmd)) begin
               m_last = 1;
               m_done = 1;
            end
         end else if (m_link) begin
            m_start = 1;
            case (b)
               8'h10: m_cmd = 1;
               8'h20: m_cmd = 2;
               8'h30: m_cmd = 3;
               default: m_err = 1;
            endcase
            if (m_cmd != 0) m_q.delete();
         end
      end
   endtask

   task automatic tick(input bit v, input logic [7:0] b,
                       input bit o, input bit a);
      bus.rx_valid = v;
      bus.rx_data = b;
      bus.opds_counter_rst = o;
      bus.send_ack = a;
      @(posedge clk);
      model_step(v, b, o, a);
      #1;
      bus.rx_valid = 0;
      bus.rx_data = 8'h00;
      bus.opds_counter_rst = 0;
      bus.send_ack = 0;
   endtask

   task automatic do_reset();
      bus.rx_valid = 0;
      bus.rx_data = 8'h00;
      bus.opds_counter_rst = 0;
      bus.send_ack = 0;
      rst = 1;
      @(posedge clk);
      model_reset();
      #1;
      rst = 0;
   endtask

   task automatic test_reset();
      logic [46:0] got;
      do_reset();
      got = {bus.start_bit, bus.valid_cmd, bus.last_opds, bus.connect,
             bus.disconnect, bus.cmd_code, bus.opds, bus.opd_cnt,
             bus.err_cmd, bus.overrun};
      checks++;
      if (got !== 47'd0) begin
         errors++;
         $display("FAIL reset_state got=%h exp=0", got);
      end
   endtask

   task automatic test_read_frame();
      do_reset();
      tick(1, 8'hA5, 0, 0);
      checks++;
      if (bus.connect !== 1'b1 || bus.start_bit !== 1'b0) begin
         errors++;
         $display("FAIL connect_pulse got=%b%b exp=10",
                  bus.connect, bus.start_bit);
      end
      tick(1, 8'h20, 0, 0);
      checks++;
      if (bus.start_bit !== 1'b1 || bus.valid_cmd !== 1'b1 ||
          bus.cmd_code !== CMD_READ) begin
         errors++;
         $display("FAIL read_start got=%b%b%b exp=1110",
                  bus.start_bit, bus.valid_cmd, bus.cmd_code);
      end
      tick(1, 8'h3C, 0, 0);
      checks++;
      if (bus.last_opds !== 1'b1 || bus.opds[7:0] !== 8'h3C ||
          bus.opd_cnt !== 3'd1 || bus.cmd_code !== CMD_READ) begin
         errors++;
         $display("FAIL read_last got=%b %h %0d %b exp=1 3c 1 10",
                  bus.last_opds, bus.opds[7:0], bus.opd_cnt, bus.cmd_code);
      end
   endtask

   task automatic test_write_hold();
      tick(0, 8'h00, 0, 1);
      checks++;
      if (bus.valid_cmd !== 1'b0 || bus.cmd_code !== CMD_NONE ||
          bus.opds[7:0] !== 8'h3C) begin
         errors++;
         $display("FAIL ack_release got=%b %b %h exp=0 00 3c",
                  bus.valid_cmd, bus.cmd_code, bus.opds[7:0]);
      end
      tick(1, 8'h10, 0, 0);
      tick(1, 8'h11, 0, 0);
      tick(1, 8'h22, 0, 0);
      checks++;
      if (bus.last_opds !== 1'b0 || bus.opd_cnt !== 3'd2) begin
         errors++;
         $display("FAIL write_mid got=%b %0d exp=0 2",
                  bus.last_opds, bus.opd_cnt);
      end
      tick(1, 8'h33, 0, 0);
      checks++;
      if (bus.last_opds !== 1'b1 || bus.opds !== 32'h00332211 ||
          bus.cmd_code !== CMD_WRITE) begin
         errors++;
         $display("FAIL write_last got=%b %h %b exp=1 00332211 01",
                  bus.last_opds, bus.opds, bus.cmd_code);
      end
      tick(1, 8'h44, 0, 0);
      checks++;
      if (bus.overrun !== 1'b1 || bus.opds !== 32'h00332211) begin
         errors++;
         $display("FAIL hold_overrun got=%b %h exp=1 00332211",
                  bus.overrun, bus.opds);
      end
      tick(0, 8'h00, 0, 1);
      tick(1, 8'h20, 0, 0);
      checks++;
      if (bus.start_bit !== 1'b1 || bus.overrun !== 1'b1) begin
         errors++;
         $display("FAIL after_ack got=%b%b exp=11",
                  bus.start_bit, bus.overrun);
      end
   endtask

   task automatic test_link_down();
      do_reset();
      tick(1, 8'h30, 0, 0);
      checks++;
      if (bus.start_bit !== 1'b0 || bus.valid_cmd !== 1'b0) begin
         errors++;
         $display("FAIL link_down_drop got=%b%b exp=00",
                  bus.start_bit, bus.valid_cmd);
      end
      tick(1, 8'hA5, 0, 0);
      tick(1, 8'h7E, 0, 0);
      checks++;
      if (bus.err_cmd !== 1'b1 || bus.start_bit !== 1'b1 ||
          bus.valid_cmd !== 1'b0 || bus.cmd_code !== CMD_NONE) begin
         errors++;
         $display("FAIL unknown_op got=%b%b%b%b exp=11000",
                  bus.err_cmd, bus.start_bit, bus.valid_cmd, bus.cmd_code);
      end
   endtask

   task automatic test_counter_rst();
      tick(1, 8'h30, 0, 0);
      tick(1, 8'hAA, 0, 0);
      tick(1, 8'hBB, 0, 0);
      checks++;
      if (bus.opd_cnt !== 3'd2 || bus.opds !== 32'h0000BBAA) begin
         errors++;
         $display("FAIL fill_two got=%0d %h exp=2 0000bbaa",
                  bus.opd_cnt, bus.opds);
      end
      tick(1, 8'hCC, 1, 0);
      checks++;
      if (bus.opd_cnt !== 3'd0 || bus.opds !== 32'h0 ||
          bus.valid_cmd !== 1'b0 || bus.cmd_code !== CMD_NONE) begin
         errors++;
         $display("FAIL counter_rst got=%0d %h %b %b exp=0 0 0 00",
                  bus.opd_cnt, bus.opds, bus.valid_cmd, bus.cmd_code);
      end
      tick(1, 8'h20, 0, 0);
      checks++;
      if (bus.start_bit !== 1'b1 || bus.cmd_code !== CMD_READ) begin
         errors++;
         $display("FAIL op_after_crst got=%b %b exp=1 10",
                  bus.start_bit, bus.cmd_code);
      end
   endtask

   task automatic test_disconnect_abort();
      do_reset();
      tick(1, 8'hA5, 0, 0);
      tick(1, 8'h10, 0, 0);
      tick(1, 8'h01, 0, 0);
      tick(1, 8'h5A, 0, 0);
      checks++;
      if (bus.disconnect !== 1'b1 || bus.valid_cmd !== 1'b0 ||
          bus.cmd_code !== CMD_NONE || bus.last_opds !== 1'b0) begin
         errors++;
         $display("FAIL disc_abort got=%b%b%b%b exp=10000",
                  bus.disconnect, bus.valid_cmd, bus.cmd_code, bus.last_opds);
      end
      tick(1, 8'h10, 0, 0);
      checks++;
      if (bus.start_bit !== 1'b0 || bus.valid_cmd !== 1'b0) begin
         errors++;
         $display("FAIL drop_after_disc got=%b%b exp=00",
                  bus.start_bit, bus.valid_cmd);
      end
   endtask

   task automatic test_rst_mid_frame();
      do_reset();
      tick(1, 8'hA5, 0, 0);
      tick(1, 8'h30, 0, 0);
      tick(1, 8'h99, 0, 0);
      do_reset();
      tick(1, 8'hA5, 0, 0);
      tick(1, 8'h20, 0, 0);
      checks++;
      if (bus.start_bit !== 1'b1 || bus.cmd_code !== CMD_READ ||
          bus.opd_cnt !== 3'd0 || bus.opds !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_frame got=%b %b %0d %h exp=1 10 0 0",
                  bus.start_bit, bus.cmd_code, bus.opd_cnt, bus.opds);
      end
   endtask

   task automatic test_random();
      logic [46:0] got, exp;
      logic [7:0]  b;
      bit          v, o, a;
      int          bad = 0;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         case ($urandom_range(0, 9))
            0: b = 8'hA5;
            1: b = 8'h5A;
            2: b = 8'h10;
            3: b = 8'h20;
            4: b = 8'h30;
            default: b = 8'($urandom);
         endcase
         v = $urandom_range(0, 3) != 0;
         o = $urandom_range(0, 39) == 0;
         a = $urandom_range(0, 5) == 0;
         tick(v, b, o, a);
         exp = {m_start, m_cmd != 0, m_last, m_conn, m_disc,
                2'(m_cmd), exp_opds(), 3'(m_q.size()), m_err, m_ovr};
         got = {bus.start_bit, bus.valid_cmd, bus.last_opds, bus.connect,
                bus.disconnect, bus.cmd_code, bus.opds, bus.opd_cnt,
                bus.err_cmd, bus.overrun};
         checks++;
         if (got !== exp) begin
            errors++;
            bad++;
            if (bad <= 10)
               $display("FAIL random_cycle%0d got=%h exp=%h", n, got, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_read_frame();
      test_write_hold();
      test_link_down();
      test_counter_rst();
      test_disconnect_abort();
      test_rst_mid_frame();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cmd_parser.md
CMD_PARSER -- requirements
Module: cmd_parser

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 rx_data  input  8  received UART byte, valid only with rx_valid.
REQ-005 rx_valid  input  1  one-cycle strobe, one byte per strobe.
REQ-006 opds_counter_rst  input  1  abort request from communication FSM.
REQ-007 send_ack  input  1  frame-complete release from communication FSM.
REQ-008 start_bit  output  1  one-cycle pulse: data-command opcode byte accepted.
REQ-009 valid_cmd  output  1  level: accepted opcode is a known data command.
REQ-010 last_opds  output  1  one-cycle pulse: final operand byte stored.
REQ-011 connect  output  1  one-cycle pulse on CONNECT byte.
REQ-012 disconnect  output  1  one-cycle pulse on DISCONNECT byte.
REQ-013 cmd_code  output  2  00 none, 01 WRITE, 10 READ, 11 FILL.
REQ-014 opds  output  32  operand buffer; first operand in bits [7:0], next in [15:8], and so on.
REQ-015 opd_cnt  output  3  operands stored in current frame (0..4).
REQ-016 err_cmd  output  1  one-cycle pulse on unknown opcode while link up.
REQ-017 overrun  output  1  sticky: byte received in S_HOLD; cleared only by rst.

Function
REQ-018 Opcodes SHALL be: 0xA5 CONNECT, 0x5A DISCONNECT, 0x10 WRITE (3 operands), 0x20 READ (1 operand), 0x30 FILL (4 operands).
REQ-019 Internal link_up flag SHALL be set by CONNECT and cleared by DISCONNECT; both bytes are decoded in every state except S_HOLD.
REQ-020 States SHALL be S_CMD, S_OPDS and S_HOLD.
REQ-021 S_CMD, rx_valid at cycle N with a data opcode and link_up=1: at N+1 start_bit=1, cmd_code set, valid_cmd=1, opd_cnt=0, opds=0; state moves to S_OPDS.
REQ-022 S_CMD, unknown opcode with link_up=1: start_bit=1 and err_cmd=1 at N+1; valid_cmd stays 0; cmd_code=00; state stays S_CMD.
REQ-023 S_CMD with link_up=0: data and unknown opcodes SHALL be silently dropped, with no output pulses.
REQ-024 CONNECT/DISCONNECT byte: the matching pulse SHALL appear at N+1; start_bit does not pulse; state is unchanged, except that DISCONNECT in S_OPDS aborts to S_CMD.
REQ-025 S_OPDS, each rx_valid byte SHALL be written to opds byte lane opd_cnt; opd_cnt increments at N+1.
REQ-026 When opd_cnt reaches the opcode's operand count, last_opds SHALL pulse in that same cycle N+1 and the state SHALL move to S_HOLD; valid_cmd and cmd_code are held.
REQ-027 S_HOLD SHALL ignore rx bytes and set overrun for each dropped byte; send_ack SHALL return the state to S_CMD and clear valid_cmd and cmd_code, while opds is retained.
REQ-028 opds_counter_rst in any state SHALL clear opd_cnt, opds, valid_cmd and cmd_code and return the state to S_CMD next cycle; link_up is unaffected.
REQ-029 Simultaneous events: opds_counter_rst wins over rx_valid, and the byte is dropped; send_ack with rx_valid in S_HOLD releases the state and drops the byte.
REQ-030 All outputs SHALL be registered; no combinational path from input to output.

Reset
REQ-031 On rst: state=S_CMD, link_up=0, overrun=0, opds=0, opd_cnt=0, cmd_code=00, and all pulses and valid_cmd are 0.
REQ-032 rst mid-frame SHALL discard the partial frame; the next byte is treated as an opcode.

Structure
REQ-033 Package comm_pkg SHALL hold the opcode constants, the cmd_t enum (2-bit) and the operand-count constants per command.
REQ-034 The block is a single module with no sub-module; the state enum is local to it.

Verification
REQ-035 rst; 0xA5 -> connect pulse N+1; then 0x20, 0x3C -> start_bit, then last_opds with opds[7:0]=0x3C, opd_cnt=1, cmd_code=10.
REQ-036 Link up; 0x10, 0x11, 0x22, 0x33 -> last_opds after third operand, opds=0x00332211; byte 0x44 in S_HOLD -> overrun=1; send_ack -> S_CMD.
REQ-037 Link down; 0x30 -> no start_bit; then 0xA5, 0x7E -> err_cmd=1, start_bit=1, valid_cmd=0.
REQ-038 FILL after 2 operands, then opds_counter_rst asserted in the same cycle as rx_valid -> opd_cnt=0, byte dropped, next 0x20 accepted as an opcode.
REQ-039 WRITE after 1 operand, then 0x5A -> disconnect pulse, frame aborted; next 0x10 dropped because link_up=0.
